// File: rtl/demux_1x4_stream.sv
// Four-way stream demultiplexer: one input word per cycle is routed by select
// into one of four 2-entry lane FIFOs, each with its own valid/ready output.
module demux_1x4_stream #(
   parameter int WIDTH = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [WIDTH-1:0]   in_data_i,
   input  logic [1:0]         in_sel_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [4*WIDTH-1:0] out_data_o,
   output logic [3:0]         out_valid_o,
   input  logic [3:0]         out_ready_i
);

   logic [3:0] lane_full;
   logic       accept;

   // Ready looks only at the selected lane's registered occupancy, so a pop in
   // the same cycle never opens a full lane.
   assign in_ready_o = ~lane_full[in_sel_i];
   assign accept     = in_valid_i & in_ready_o;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [WIDTH-1:0] head_r;
      logic [WIDTH-1:0] tail_r;
      logic [1:0]       cnt_r;
      logic             push;
      logic             pop;

      assign push = accept & (in_sel_i == 2'(k));
      assign pop  = (cnt_r != 2'd0) & out_ready_i[k];

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            cnt_r  <= 2'd0;
            head_r <= '0;
            tail_r <= '0;
         end else begin
            case (cnt_r)
               2'd0: begin
                  if (push) begin
                     head_r <= in_data_i;
                     cnt_r  <= 2'd1;
                  end
               end
               2'd1: begin
                  // Push with pop replaces the head in place; head is left
                  // untouched on a plain pop so the output holds its value.
                  if (push && pop) begin
                     head_r <= in_data_i;
                  end else if (push) begin
                     tail_r <= in_data_i;
                     cnt_r  <= 2'd2;
                  end else if (pop) begin
                     cnt_r  <= 2'd0;
                  end
               end
               2'd2: begin
                  if (pop) begin
                     head_r <= tail_r;
                     cnt_r  <= 2'd1;
                  end
               end
               default: cnt_r <= 2'd0;
            endcase
         end
      end

      assign lane_full[k]                  = (cnt_r == 2'd2);
      assign out_valid_o[k]                = (cnt_r != 2'd0);
      assign out_data_o[k*WIDTH +: WIDTH]  = head_r;
   end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Scoreboard bench for demux_1x4_stream: per-lane expected-word queues are
// filled on modelled acceptance and compared against the lane outputs.
module tb_demux_1x4_stream;
   localparam int W = 64;
   typedef logic [W-1:0]   word_t;
   typedef logic [4*W-1:0] big_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   big_t         out_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;

   demux_1x4_stream #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .in_data_i  (in_data),
      .in_sel_i   (in_sel),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .out_data_o (out_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready)
   );

   always #10 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   word_t exp_q [4][$];
   word_t last_head [4];
   bit    started  = 1'b0;
   bit    last_acc = 1'b0;

   task automatic chk(input string name, input big_t act, input big_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: lanes are plain FIFOs of capacity two.
   initial forever begin
      @(posedge clk);
      last_acc = 1'b0;
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_head[k] = '0;
         end
         started = 1'b1;
      end else if (started) begin
         bit acc;
         acc = in_valid && (exp_q[in_sel].size() < 2);
         for (int k = 0; k < 4; k++)
            if (out_ready[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
         if (acc) exp_q[in_sel].push_back(in_data);
         for (int k = 0; k < 4; k++)
            if (exp_q[k].size() != 0) last_head[k] = exp_q[k][0];
         last_acc = acc;
      end
   end

   // Monitor: compares every lane on the falling edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("in_ready", big_t'(in_ready), big_t'(exp_q[in_sel].size() < 2));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid[%0d]", k), big_t'(out_valid[k]),
                big_t'(exp_q[k].size() != 0));
            chk($sformatf("data[%0d]", k), big_t'(out_data[k*W +: W]),
                big_t'((exp_q[k].size() != 0) ? exp_q[k][0] : last_head[k]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [1:0] s, input word_t d);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = '1;
      out_ready = 4'hF;
      repeat (2) step();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_valid", big_t'(out_valid), big_t'(0));
      chk("rst_data", out_data, big_t'(0));
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         chk("rst_ready", big_t'(in_ready), big_t'(1));
      end

      // single routed word
      out_ready = 4'h0;
      send(2'd2, word_t'(64'hA5));
      step();
      in_valid = 1'b0;
      chk("single_valid", big_t'(out_valid), big_t'(4'b0100));
      chk("single_data", big_t'(out_data[2*W +: W]), big_t'(64'hA5));
      out_ready = 4'b0100;
      step();
      out_ready = 4'h0;
      chk("single_pop", big_t'(out_valid), big_t'(0));

      // fill and backpressure
      send(2'd1, word_t'(64'h11));
      step();
      send(2'd1, word_t'(64'h22));
      step();
      in_valid = 1'b0;
      in_sel   = 2'd1;
      #1 chk("full_ready1", big_t'(in_ready), big_t'(0));
      in_sel = 2'd0;
      #1 chk("full_ready0", big_t'(in_ready), big_t'(1));
      chk("full_head", big_t'(out_data[W +: W]), big_t'(64'h11));
      out_ready = 4'b0010;
      step();
      out_ready = 4'h0;
      chk("after_pop_head", big_t'(out_data[W +: W]), big_t'(64'h22));
      in_sel = 2'd1;
      #1 chk("after_pop_ready", big_t'(in_ready), big_t'(1));
      out_ready = 4'b0010;
      step();
      out_ready = 4'h0;

      // simultaneous push and pop
      send(2'd3, word_t'(64'h33));
      step();
      send(2'd3, word_t'(64'h44));
      out_ready = 4'b1000;
      step();
      in_valid  = 1'b0;
      out_ready = 4'h0;
      chk("pp_valid", big_t'(out_valid), big_t'(4'b1000));
      chk("pp_head", big_t'(out_data[3*W +: W]), big_t'(64'h44));
      out_ready = 4'b1000;
      step();
      out_ready = 4'h0;

      // throughput and ordering
      out_ready = 4'hF;
      for (int i = 0; i < 64; i++) begin
         send(2'(i % 4), word_t'(i));
         #1 chk("tput_ready", big_t'(in_ready), big_t'(1));
         step();
      end
      in_valid = 1'b0;
      step();

      // reset mid-operation
      out_ready = 4'h0;
      for (int i = 0; i < 4; i++) begin
         send((i < 2) ? 2'd0 : 2'd2, word_t'(64'h100 + i));
         step();
      end
      in_valid = 1'b0;
      chk("mid_full", big_t'(out_valid), big_t'(4'b0101));
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_valid", big_t'(out_valid), big_t'(0));
      chk("mid_rst_data", out_data, big_t'(0));
      send(2'd0, word_t'(64'h5A));
      step();
      in_valid = 1'b0;
      chk("mid_new_valid", big_t'(out_valid), big_t'(4'b0001));
      chk("mid_new_data", big_t'(out_data[W-1:0]), big_t'(64'h5A));
      out_ready = 4'hF;
      step();

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         out_ready = 4'($urandom());
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(3) != 0);
            in_sel   = 2'($urandom_range(3));
            in_data  = {$urandom(), $urandom()};
         end
         reset = ($urandom_range(199) == 0);
         step();
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
